// File: rtl/alu_stimulus_sequencer_pkg.sv
// Shared types, constants and golden model for the 1-bit ALU stimulus sequencer.
package alu_stimulus_sequencer_pkg;

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned RES_W   = 4;
  localparam int unsigned TABLE_W = NUM_VEC * RES_W;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned HOLD_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRIVE     = 2'd1,
    ST_SAMPLE    = 2'd2,
    ST_WAIT_STEP = 2'd3
  } state_e;

  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_AND  = 2'b01;
  localparam logic [1:0] SEL_CMP  = 2'b10;
  localparam logic [1:0] SEL_OR   = 2'b11;

  // One ALU response, MSB first as it is stored in the result table.
  typedef struct packed {
    logic f1;
    logic f2;
    logic f3;
    logic f4;
  } alu_res_t;

  // Slot idx={S1,S0,A,B} holds {F1,F2,F3,F4}; slot 15 is the top nibble.
  localparam logic [TABLE_W-1:0] ALU_GOLDEN_TABLE = 64'hEDB7_16AD_8421_7654;

  function automatic alu_res_t alu_golden(input logic [1:0] sel, input logic a, input logic b);
    alu_res_t r;
    r = '0;
    case (sel)
      SEL_PASS: r = '{f1: 1'b0,    f2: 1'b1,    f3: a,        f4: b};
      SEL_AND:  r = '{f1: a & b,   f2: a & ~b,  f3: ~a & b,   f4: ~a & ~b};
      SEL_CMP:  r = '{f1: ~a,      f2: ~b,      f3: a ^ b,    f4: ~(a ^ b)};
      SEL_OR:   r = '{f1: a | b,   f2: a | ~b,  f3: ~a | b,   f4: ~a | ~b};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_stimulus_sequencer_settle_timer.sv
// Loadable down-counter that measures how long a vector is held before sampling.
module alu_stimulus_sequencer_settle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/alu_stimulus_sequencer.sv
// Walks all 16 {S1,S0,A,B} vectors into a 1-bit ALU, records F1..F4 and counts
// disagreements with the golden model; optional single-step pacing.
module alu_stimulus_sequencer
  import alu_stimulus_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  output logic               A,
  output logic               B,
  output logic               S1,
  output logic               S0,
  input  logic               F1,
  input  logic               F2,
  input  logic               F3,
  input  logic               F4,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] result_table,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               mismatch
);

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(NUM_VEC);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TABLE_W-1:0] table_q, table_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               step_mode_q, step_mode_d;

  logic               timer_load_c;
  logic               timer_en_c;
  logic               timer_expired_c;
  alu_res_t           sample_c;

  alu_stimulus_sequencer_settle_timer #(
    .W (HOLD_W)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load_c),
    .load_val  (HOLD_RELOAD),
    .en        (timer_en_c),
    .expired_c (timer_expired_c)
  );

  assign sample_c = {F1, F2, F3, F4};

  // Next-state and register updates; the stimulus is the vector index itself.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    table_d      = table_q;
    mcnt_d       = mcnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    step_mode_d  = step_mode_q;
    timer_load_c = 1'b0;
    timer_en_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          idx_d        = '0;
          table_d      = '0;
          mcnt_d       = '0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
          step_mode_d  = step_mode;
          timer_load_c = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_expired_c) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_en_c = 1'b1;
        end
      end
      ST_SAMPLE: begin
        table_d[{idx_q, 2'b00} +: RES_W] = sample_c;
        if ((sample_c != alu_golden(idx_q[3:2], idx_q[1], idx_q[0])) && (mcnt_q != CNT_MAX)) begin
          mcnt_d = mcnt_q + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d        = idx_q + IDX_W'(1);
          timer_load_c = 1'b1;
          state_d      = step_mode_q ? ST_WAIT_STEP : ST_DRIVE;
        end
      end
      ST_WAIT_STEP: begin
        if (step) begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      table_q     <= '0;
      mcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      table_q     <= table_d;
      mcnt_q      <= mcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_mode_q <= step_mode_d;
    end
  end

  assign {S1, S0, A, B} = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign result_table   = table_q;
  assign mismatch_cnt   = mcnt_q;
  assign mismatch       = (mcnt_q != '0);

endmodule

// File: tb/tb_alu_stimulus_sequencer.sv
// Scoreboard bench for alu_stimulus_sequencer: a behavioural ALU (with injectable
// faults) feeds the DUT, expected run results are queued and checked at each done.
module tb_alu_stimulus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic        a, b, s1, s0, f1, f2, f3, f4, busy, done, mismatch;
  logic [63:0] res_tbl;
  logic [4:0]  mcnt;

  logic        start3 = 1'b0, zero3 = 1'b0;
  logic        a3, b3, s13, s03, f13, f23, f33, f43, busy3, done3, mismatch3;
  logic [63:0] res_tbl3;
  logic [4:0]  mcnt3;

  int          alu_mode = 0;
  logic [63:0] fault_mask = '0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [63:0] tbl;
    logic [4:0]  cnt;
    int          len;
  } exp_t;
  exp_t exp_q[$];

  // Truth table of the ALU written straight from its per-select equations.
  function automatic logic [3:0] tb_golden(input int idx);
    logic [3:0] v;
    logic       x, y;
    v = 4'(idx);
    x = v[1];
    y = v[0];
    case (v[3:2])
      2'd0:    return {1'b0, 1'b1, x, y};
      2'd1:    return {x & y, x & ~y, ~x & y, ~x & ~y};
      2'd2:    return {~x, ~y, x ^ y, ~(x ^ y)};
      default: return {x | y, x | ~y, ~x | y, ~x | ~y};
    endcase
  endfunction

  // ALU under test: mode 0 correct, 1 F4 stuck at 0, 2 per-vector XOR fault mask.
  function automatic logic [3:0] alu_out(input int mode, input logic [63:0] mask, input int idx);
    logic [3:0] r;
    r = tb_golden(idx);
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) r = r ^ mask[4*idx +: 4];
    return r;
  endfunction

  always_comb {f1, f2, f3, f4} = alu_out(alu_mode, fault_mask, int'({s1, s0, a, b}));
  always_comb {f13, f23, f33, f43} = tb_golden(int'({s13, s03, a3, b3}));

  alu_stimulus_sequencer #(.HOLD_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .A(a), .B(b), .S1(s1), .S0(s0), .F1(f1), .F2(f2), .F3(f3), .F4(f4),
    .busy(busy), .done(done), .result_table(res_tbl), .mismatch_cnt(mcnt), .mismatch(mismatch)
  );

  alu_stimulus_sequencer #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .step_mode(zero3), .step(zero3),
    .A(a3), .B(b3), .S1(s13), .S0(s03), .F1(f13), .F2(f23), .F3(f33), .F4(f43),
    .busy(busy3), .done(done3), .result_table(res_tbl3), .mismatch_cnt(mcnt3), .mismatch(mismatch3)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_expect(input int len);
    exp_t e;
    logic [3:0] r;
    e.tbl = '0;
    e.cnt = '0;
    e.len = len;
    for (int i = 0; i < 16; i++) begin
      r = alu_out(alu_mode, fault_mask, i);
      e.tbl[4*i +: 4] = r;
      if (r != tb_golden(i)) e.cnt = e.cnt + 5'd1;
    end
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      tick(1);
      k++;
    end
    if (!done) fail_now(name);
  endtask

  // Monitor: counts busy cycles and checks the completed run against the scoreboard.
  int   busy_len = 0;
  logic done_prev = 1'b0;
  exp_t got_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_len  = 0;
        done_prev = 1'b0;
      end else begin
        if (busy) busy_len++;
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            got_e = exp_q.pop_front();
            check("result_table", res_tbl, got_e.tbl);
            check("mismatch_cnt", 64'(mcnt), 64'(got_e.cnt));
            check("mismatch", 64'(mismatch), 64'(got_e.cnt != 5'd0));
            check("final_stimulus", 64'({s1, s0, a, b}), 64'hF);
            if (got_e.len > 0) check("busy_length", 64'(busy_len), 64'(got_e.len));
          end
          busy_len = 0;
        end
        done_prev = done;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    int len3;
    logic [63:0] gold;

    gold = '0;
    for (int i = 0; i < 16; i++) gold[4*i +: 4] = tb_golden(i);

    tick(3);
    check("reset_table", res_tbl, 64'h0);
    check("reset_outputs", 64'({a, b, s1, s0, busy, done, mismatch, mcnt}), 64'h0);
    rst_n = 1'b1;
    tick(2);

    // Correct ALU, auto run, with stray start and step pulses mid-run.
    alu_mode = 0;
    push_expect(32);
    pulse_start();
    tick(4);
    start = 1'b1; tick(1); start = 1'b0;
    tick(4);
    step = 1'b1; tick(1); step = 1'b0;
    tick(9);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done("done_auto", 60);
    check("literal_golden_table", res_tbl, 64'hEDB7_16AD_8421_7654);
    tick(2);

    // F4 stuck at 0.
    alu_mode = 1;
    push_expect(32);
    pulse_start();
    wait_done("done_f4_stuck", 60);
    check("f4_stuck_cnt", 64'(mcnt), 64'd8);
    check("f4_stuck_bit0", res_tbl & {16{4'b0001}}, 64'h0);
    tick(2);

    // Random per-vector faults.
    for (int r = 0; r < 6; r++) begin
      alu_mode = 2;
      fault_mask = '0;
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 2) == 0) fault_mask[4*i +: 4] = 4'($urandom_range(1, 15));
      end
      push_expect(32);
      pulse_start();
      wait_done("done_random", 60);
      tick($urandom_range(1, 3));
    end

    // Single-step mode.
    alu_mode = 0;
    push_expect(0);
    step_mode = 1'b1;
    pulse_start();
    step_mode = 1'b0;
    k = 0;
    while ({s1, s0, a, b} != 4'd1 && k < 10) begin tick(1); k++; end
    if ({s1, s0, a, b} != 4'd1) fail_now("step_first_pause");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if ({s1, s0, a, b} != 4'd1 || !busy) bad++;
    end
    check("step_pause_hold", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      step = 1'b1; tick(1); step = 1'b0;
      tick(3 + $urandom_range(0, 3));
      if ({s1, s0, a, b} != ((i < 15) ? 4'(i + 1) : 4'hF)) bad++;
    end
    check("step_progress", 64'(bad), 64'd0);
    check("step_done", 64'(done), 64'd1);
    tick(2);

    // Asynchronous reset in the middle of vector 7.
    alu_mode = 0;
    push_expect(32);
    pulse_start();
    k = 0;
    while ({s1, s0, a, b} != 4'd7 && k < 40) begin tick(1); k++; end
    if ({s1, s0, a, b} != 4'd7) fail_now("reach_vector7");
    #2 rst_n = 1'b0;
    #1;
    check("abort_table", res_tbl, 64'h0);
    check("abort_outputs", 64'({a, b, s1, s0, busy, done, mismatch, mcnt}), 64'h0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("after_abort_busy", 64'(busy), 64'd0);
    push_expect(32);
    pulse_start();
    wait_done("done_after_abort", 60);
    tick(2);

    // HOLD_CYCLES=3 with start held high: back-to-back runs.
    start3 = 1'b1;
    tick(1);
    len3 = 0;
    k = 0;
    while (!done3 && k < 200) begin
      if (busy3) len3++;
      tick(1);
      k++;
    end
    if (!done3) fail_now("done_hold3");
    check("hold3_busy_length", 64'(len3), 64'd64);
    check("hold3_table", res_tbl3, gold);
    check("hold3_mismatch", 64'({mismatch3, mcnt3}), 64'h0);
    tick(1);
    check("hold3_restart", 64'({done3, busy3}), 64'b01);
    start3 = 1'b0;
    k = 0;
    while (!done3 && k < 100) begin tick(1); k++; end
    check("hold3_second_done", 64'(done3), 64'd1);

    tick(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
